spi_reg_master: RTL

Register-access front end that sits directly upstream of the team's SPI master driver (`spi_drv`). It accepts read/write register commands from the host over a valid/ready interface and queues them in a small FIFO. Each command is formatted as one SPI frame: R/W bit, then address, then data. The block runs the `spi_drv` start/ready handshake and returns one response per command, carrying read data or an error flag.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_cmd_fifo.sv | 67 ++++++
 rtl/spi_reg_master.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI register-access front end.
// State encoding, command record and R/W constants.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } spi_reg_state_t;

  localparam logic SPI_RD = 1'b1;
  localparam logic SPI_WR = 1'b0;

  localparam int SPI_ADDR_W = 7;
  localparam int SPI_DATA_W = 16;

  typedef struct packed {
    logic                  rw;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] wdata;
  } spi_cmd_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Command queue for spi_reg_master.
// A pushed entry is offered to the reader one cycle after it lands.
module spi_cmd_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             used
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [AW:0]      vis_q, vis_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full = (wr_q[AW] != rd_q[AW]) &&
                (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (vis_q == rd_q);
  assign used = (wr_q != rd_q);
  assign dout = mem_q[rd_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop = pop && !empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    vis_d = wr_q;
    if (do_push) wr_d = wr_q + ONE;
    if (do_pop) rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      vis_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      vis_q <= vis_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// Register read/write front end driving spi_drv.
// Queues host commands, frames them, returns one response each.
module spi_reg_master
  import spi_pkg::*;
#(
  parameter int SPI_MAXLEN    = 32,
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rw,
  input  logic [ADDR_W-1:0]             cmd_addr,
  input  logic [DATA_W-1:0]             cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_rw,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          spi_start_cmd,
  output logic [$clog2(SPI_MAXLEN):0]   spi_n_clks,
  output logic [SPI_MAXLEN-1:0]         spi_tx_data,
  input  logic                          spi_drv_rdy,
  input  logic [SPI_MAXLEN-1:0]         spi_rx_miso,
  output logic                          busy
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int NW = $clog2(SPI_MAXLEN) + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  if (FRAME > SPI_MAXLEN) begin : g_len_chk
    $error("frame wider than SPI_MAXLEN");
  end

  spi_reg_state_t        state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic                  start_q, start_d;
  logic [NW-1:0]         ncl_q, ncl_d;
  logic [SPI_MAXLEN-1:0] tx_q, tx_d;
  logic                  rw_q, rw_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  rv_q, rv_d;

  logic [FRAME-1:0]  fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_used;
  logic              pop;
  logic              f_rw;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_wdata;
  logic [DATA_W-1:0] f_data;
  logic              unused_rx;

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid),
    .din     ({cmd_rw, cmd_addr, cmd_wdata}),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .used    (fifo_used)
  );

  assign f_rw = fifo_dout[FRAME-1];
  assign f_addr = fifo_dout[FRAME-2 -: ADDR_W];
  assign f_wdata = fifo_dout[DATA_W-1:0];
  assign f_data = (f_rw == SPI_RD) ? '0 : f_wdata;
  assign unused_rx = ^spi_rx_miso[SPI_MAXLEN-1:DATA_W];

  assign cmd_ready = !fifo_full;
  assign rsp_valid = rv_q;
  assign rsp_rw = rw_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  assign spi_start_cmd = start_q;
  assign spi_n_clks = ncl_q;
  assign spi_tx_data = tx_q;
  assign busy = (state_q != IDLE) || fifo_used;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    start_d = start_q;
    ncl_d = ncl_q;
    tx_d = tx_q;
    rw_d = rw_q;
    rdata_d = rdata_q;
    err_d = err_q;
    rv_d = rv_q;
    pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && spi_drv_rdy) begin
          pop = 1'b1;
          tx_d = SPI_MAXLEN'({f_rw, f_addr, f_data});
          ncl_d = NW'(FRAME);
          rw_d = f_rw;
          start_d = 1'b1;
          cnt_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (!spi_drv_rdy) begin
          start_d = 1'b0;
          state_d = BUSY;
        end else if (cnt_q == TW'(START_TIMEOUT - 1)) begin
          start_d = 1'b0;
          err_d = 1'b1;
          rdata_d = '0;
          rv_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      BUSY: begin
        // No timeout here: frame time depends on the driver's clock divide
        if (spi_drv_rdy) begin
          rdata_d = (rw_q == SPI_RD) ? spi_rx_miso[DATA_W-1:0] : '0;
          err_d = 1'b0;
          rv_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_d = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      start_q <= 1'b0;
      ncl_q <= '0;
      tx_q <= '0;
      rw_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      start_q <= start_d;
      ncl_q <= ncl_d;
      tx_q <= tx_d;
      rw_q <= rw_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      rv_q <= rv_d;
    end
  end

endmodule
